// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions used by both the transmitter and the receiver.
//   - uart_state_e : receive FSM state encoding (2 bits)
//   - DATA_BITS / STOP_BITS : 8N1 frame shape
//   - SYNC_STAGES  : depth of the rxd metastability synchroniser
//   - clks_per_bit(): clock divisor, rounded to nearest, so TX and RX agree
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DATA_BITS   = 8;
    localparam int STOP_BITS   = 1;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Divisor rounded to the nearest integer: 27 MHz / 115200 -> 234.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte-output handshake between the UART receiver and its core-side consumer.
//   rx_data      : received byte, stable while rx_valid=1
//   rx_valid     : byte available, held until accepted
//   rx_ready     : consumer accepts when rx_valid & rx_ready at a clk edge
//   rx_frame_err : qualifies rx_data, stop bit was sampled low
//   rx_overrun   : one-cycle pulse, a completed byte was dropped
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Brings the asynchronous rxd pin into the clk domain and forms the 2-of-3
// majority vote of the samples taken at cnt = H-1, H and H+1.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_rxd        : raw serial line
//   i_active     : parent FSM is inside a frame (sampling enabled)
//   i_cnt        : parent bit-period counter
//   o_rxd_s      : synchronised line
//   o_primed     : synchroniser has been flushed since reset, o_rxd_s is real
//   o_maj_now    : majority, valid combinationally while i_cnt == H+1
//   o_maj        : majority latched at i_cnt == H+1, held for the rest of the bit
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int H     = 117
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rxd,
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_rxd_s,
    output logic             o_primed,
    output logic             o_maj_now,
    output logic             o_maj
);

    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(H + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_primed;
    logic                   r_s0;
    logic                   r_s1;
    logic                   r_maj;
    logic                   w_rxd_s;
    logic                   w_maj_now;

    // The synchroniser resets to idle-high, which is not a real observation
    // of the line. r_primed fills with ones at the same rate the real rxd
    // value propagates through, so o_primed marks when o_rxd_s is trustworthy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '1;
            r_primed <= '0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            r_primed <= {r_primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rxd_s   = r_sync[SYNC_STAGES-1];
    // Third vote is the live sample at H+1, so the result is usable that cycle.
    assign w_maj_now = (r_s0 & r_s1) | (r_s0 & w_rxd_s) | (r_s1 & w_rxd_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0  <= 1'b1;
            r_s1  <= 1'b1;
            r_maj <= 1'b1;
        end else if (i_active) begin
            if (i_cnt == CNT_EARLY) r_s0  <= w_rxd_s;
            if (i_cnt == CNT_MID)   r_s1  <= w_rxd_s;
            if (i_cnt == CNT_LATE)  r_maj <= w_maj_now;
        end
    end

    assign o_rxd_s   = w_rxd_s;
    assign o_primed  = r_primed[SYNC_STAGES-1];
    assign o_maj_now = w_maj_now;
    assign o_maj     = r_maj;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver. Rebuilds bytes LSB first from the asynchronous rxd
// line and presents them on a one-entry valid/ready holding register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_rxd      : serial line, idle high
//   rx         : uart_rx_if.master (rx_data/rx_valid/rx_ready/rx_frame_err/
//                rx_overrun)
// Parameters: CLK_HZ, BAUD, CLKS_PER_BIT (>= 8, nearest-rounded divisor).
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_rxd,
    uart_rx_if.master rx
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LATE = CNT_W'(H + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [BIT_W-1:0]     w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_armed;
    logic                 w_armed_next;

    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_data_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic                 r_frame_err;
    logic                 w_frame_err_next;
    logic                 r_overrun;
    logic                 w_overrun_next;

    logic                 w_complete;
    logic                 w_load;
    logic                 w_rxd_s;
    logic                 w_primed;
    logic                 w_maj_now;
    logic                 w_maj;
    logic                 w_active;

    assign w_active = (r_state != ST_IDLE);

    uart_rx_sampler #(
        .CNT_W (CNT_W),
        .H     (H)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rxd     (i_rxd),
        .i_active  (w_active),
        .i_cnt     (r_cnt),
        .o_rxd_s   (w_rxd_s),
        .o_primed  (w_primed),
        .o_maj_now (w_maj_now),
        .o_maj     (w_maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_armed     <= w_armed_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        // A start is only accepted once the line has been seen high since the
        // previous start. A held-low break therefore yields a single 0x00 byte,
        // and a frame whose stop bit is low can still chain straight into the
        // next start if any of its bits were high.
        w_armed_next   = r_armed | (w_primed & w_rxd_s);
        w_complete     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (r_armed && !w_rxd_s) begin
                    w_state_next = ST_START;
                    w_armed_next = 1'b0;
                end
            end

            ST_START: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LATE && w_maj_now) begin
                    // Start bit did not hold at mid-bit: treat as a glitch.
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = ST_DATA;
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                end
            end

            ST_DATA: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    // Right shift: the first bit received ends up in bit 0.
                    w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + BIT_W'(1);
                    end
                end
            end

            ST_STOP: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                // Finishing at mid-stop leaves half a bit to catch a
                // back-to-back start edge.
                if (r_cnt == CNT_LATE) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Holding register: a completed byte is taken if the slot is empty or is
    // being drained on this very edge; otherwise it is dropped and flagged.
    always_comb begin
        w_data_next      = r_data;
        w_valid_next     = r_valid;
        w_frame_err_next = r_frame_err;
        w_load           = w_complete & (~r_valid | rx.rx_ready);
        w_overrun_next   = w_complete & ~w_load;

        if (w_load) begin
            w_data_next      = r_shift;
            w_frame_err_next = ~w_maj_now;
            w_valid_next     = 1'b1;
        end else if (r_valid && rx.rx_ready) begin
            w_valid_next = 1'b0;
        end
    end

    assign rx.rx_data      = r_data;
    assign rx.rx_valid     = r_valid;
    assign rx.rx_frame_err = r_frame_err;
    assign rx.rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives 8N1 frames onto rxd and compares every delivered byte against a
// queue of the bytes the bench itself put on the line.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT = 234;

    logic clk = 1'b0;
    logic rst_n;
    logic rxd;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if rx_if ();

    uart_rx #(
        .CLK_HZ (27000000),
        .BAUD   (115200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rxd (rxd),
        .rx    (rx_if)
    );

    logic [7:0] got_data[$];
    logic       got_fe[$];
    int         got_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_fe[$];
    int         n_ovr    = 0;
    int         n_checks = 0;
    int         n_err    = 0;

    // Record every accepted byte and every overrun-active cycle.
    always @(negedge clk) begin
        if (rst_n && rx_if.rx_valid && rx_if.rx_ready) begin
            got_data.push_back(rx_if.rx_data);
            got_fe.push_back(rx_if.rx_frame_err);
            got_cyc.push_back(cyc);
        end
        if (rst_n && rx_if.rx_overrun) n_ovr++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame is start(0), 8 data bits LSB first, stop bit.
    // Expected output is the byte itself with frame_err = ~stop.
    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            wait_clks(bclk);
        end
        exp_data.push_back(b);
        exp_fe.push_back(~stop_bit);
    endtask

    task automatic check_all(input string tag);
        check({tag, " count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s byte%0d data", tag, i), {24'd0, got_data[i]}, {24'd0, exp_data[i]});
            check($sformatf("%s byte%0d ferr", tag, i), {31'd0, got_fe[i]}, {31'd0, exp_fe[i]});
        end
        got_data.delete();
        got_fe.delete();
        got_cyc.delete();
        exp_data.delete();
        exp_fe.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         t0;
        int         lat;
        int         ov0;

        rst_n          = 1'b0;
        rxd            = 1'b1;
        rx_if.rx_ready = 1'b1;
        wait_clks(3);
        check("reset valid", {31'd0, rx_if.rx_valid}, 0);
        check("reset data", {24'd0, rx_if.rx_data}, 0);
        check("reset ferr", {31'd0, rx_if.rx_frame_err}, 0);
        check("reset overrun", {31'd0, rx_if.rx_overrun}, 0);
        rst_n = 1'b1;
        wait_clks(20);

        // Single byte with latency measurement from the start edge.
        t0 = cyc;
        send_byte(8'hA5, BIT, 1'b1);
        wait_clks(2 * BIT);
        lat = (got_cyc.size() > 0) ? got_cyc[0] - t0 : -1;
        n_checks++;
        assert (lat >= 2226 && lat <= 2228) else begin
            n_err++;
            $error("FAIL latency: observed %0d expected 2227+-1", lat);
        end
        $display("single 0xA5 latency %0d clks", lat);
        check_all("single");

        // Back-to-back frames, no idle gap.
        send_byte(8'h00, BIT, 1'b1);
        send_byte(8'hFF, BIT, 1'b1);
        send_byte(8'h55, BIT, 1'b1);
        wait_clks(2 * BIT);
        $display("back-to-back 0x00 0xFF 0x55 sent");
        check_all("b2b");

        // Short low glitch must not produce a byte; a real frame follows.
        rxd = 1'b0;
        wait_clks(50);
        rxd = 1'b1;
        wait_clks(300);
        check_all("glitch");
        send_byte(8'h3C, BIT, 1'b1);
        wait_clks(2 * BIT);
        $display("glitch then 0x3C sent");
        check_all("after glitch");

        // Low stop bit, then line held low: one extra 0x00 break byte only.
        send_byte(8'h81, BIT, 1'b0);
        exp_data.push_back(8'h00);
        exp_fe.push_back(1'b1);
        wait_clks(25 * BIT);
        rxd = 1'b1;
        wait_clks(2 * BIT);
        $display("0x81 with low stop then break");
        check_all("break");

        // Overrun: second byte dropped while the first is still held.
        rx_if.rx_ready = 1'b0;
        ov0 = n_ovr;
        send_byte(8'h11, BIT, 1'b1);
        send_byte(8'h22, BIT, 1'b1);
        void'(exp_data.pop_back());
        void'(exp_fe.pop_back());
        wait_clks(BIT);
        check("overrun held valid", {31'd0, rx_if.rx_valid}, 1);
        check("overrun held data", {24'd0, rx_if.rx_data}, 32'h11);
        check("overrun held ferr", {31'd0, rx_if.rx_frame_err}, 0);
        check("overrun pulse cycles", n_ovr - ov0, 1);
        rx_if.rx_ready = 1'b1;
        wait_clks(2);
        check("drain valid", {31'd0, rx_if.rx_valid}, 0);
        check("drain data hold", {24'd0, rx_if.rx_data}, 32'h11);
        $display("overrun 0x11/0x22 then drain");
        check_all("overrun");

        // Baud skew, random bytes, back-to-back.
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            send_byte(b, 225, 1'b1);
            $display("skew 225 byte %02h", b);
        end
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            send_byte(b, 243, 1'b1);
            $display("skew 243 byte %02h", b);
        end
        wait_clks(2 * BIT);
        check_all("skew");

        // Reset mid-frame with a held byte pending; released while line is low.
        rx_if.rx_ready = 1'b0;
        send_byte(8'h77, BIT, 1'b1);
        void'(exp_data.pop_back());
        void'(exp_fe.pop_back());
        wait_clks(BIT);
        check("pre-reset valid", {31'd0, rx_if.rx_valid}, 1);
        rxd = 1'b0;
        wait_clks(BIT);
        rxd = 1'b1;
        wait_clks(BIT);
        rxd = 1'b0;
        wait_clks(100);
        rst_n = 1'b0;
        #1;
        check("midreset valid", {31'd0, rx_if.rx_valid}, 0);
        check("midreset data", {24'd0, rx_if.rx_data}, 0);
        check("midreset ferr", {31'd0, rx_if.rx_frame_err}, 0);
        check("midreset overrun", {31'd0, rx_if.rx_overrun}, 0);
        wait_clks(10);
        rx_if.rx_ready = 1'b1;
        rst_n = 1'b1;
        wait_clks(300);
        rxd = 1'b1;
        wait_clks(3 * BIT);
        check_all("reset flush");
        send_byte(8'hC3, BIT, 1'b1);
        wait_clks(2 * BIT);
        $display("post-reset 0xC3 sent");
        check_all("post reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
